ms_sync_producer: RTL and testbench
===================================

// Module: ms_sync_producer
//
// PURPOSE
// - Master-side producer for a master-slave (shared-variable) channel.
// - Drives the slave's integer data input and its one-cycle "sync" (new-value) strobe.
// - Accepts words from an upstream valid/ready source and buffers them in a small FIFO.
// - Paces emission so the slave sees at most one sync strobe per PERIOD cycles.
// - The channel has no backpressure, so pacing and buffering live here, not in the slave.
//
// PARAMETERS
// DEPTH   4   FIFO entries; power of two, >= 2
// PERIOD  2   minimum cycles between consecutive sync strobes; >= 1 (1 = back-to-back allowed)
//
// PORTS
// clk         input   1   clock, all state updates on posedge
// rst         input   1   synchronous, active-low reset (0 = reset)
// in_data     input   32  upstream word (signed integer)
// in_valid    input   1   upstream word present
// in_ready    output  1   block can accept in_data this cycle
// m_out       output  32  value presented to the slave data input (signed integer)
// m_out_sync  output  1   one-cycle strobe: m_out carries a new value this cycle
// fifo_count  output  3   FIFO occupancy, 0..DEPTH ($clog2(DEPTH)+1 bits)
// sent_count  output  16  number of strobes issued; wraps 16'hFFFF -> 0
//
// BEHAVIOUR
// - One clock domain. Reset is synchronous and active-low: sampled only on posedge clk with rst==0.
// - Reset values:
//   - m_out = 0, m_out_sync = 0, fifo_count = 0, sent_count = 0.
//   - FIFO pointers = 0; pace counter = 0; section = SEC_IDLE.
// - in_ready = rst && (fifo_count != DEPTH); combinational from registered state; 0 during reset.
// - Push: on an edge with in_valid && in_ready, write in_data at the tail and increment occupancy.
// - Push is refused while full, even if a pop occurs in the same cycle; no full-bypass.
// - Sections:
//   - SEC_IDLE: pace counter == 0; may emit.
//   - SEC_PACE: pace counter > 0; emission is blocked.
// - Emit condition at an edge: section == SEC_IDLE && fifo_count != 0, using start-of-cycle occupancy.
// - Actions on emit:
//   - m_out <= head word; m_out_sync <= 1; pop head; sent_count increments.
//   - pace counter <= PERIOD-1.
//   - Next section = SEC_PACE if PERIOD > 1, else SEC_IDLE.
// - Otherwise m_out_sync <= 0, and m_out holds its last value; the slave may re-sample it freely.
// - SEC_PACE: pace counter decrements each cycle; returns to SEC_IDLE on the edge where it reaches 0.
// - Latency: a word pushed at edge N into an empty FIFO, in SEC_IDLE, is on m_out with m_out_sync=1 after edge N+1.
// - No empty-FIFO bypass.
// - Simultaneous push and pop: occupancy unchanged; ordering strictly FIFO.
// - Pointer wrap: pointers are modulo DEPTH; occupancy is tracked separately (no full/empty aliasing).
// - Reset mid-operation flushes all buffered words (lost by design), clears the pace counter, and drops m_out_sync.
// - m_out, m_out_sync and sent_count are registered outputs; no combinational path from in_* to m_*.
//
// TESTING
// 1. Reset: hold rst=0 for 3 cycles with in_valid=1.
//    -> in_ready=0, m_out=0, m_out_sync=0, counts 0; nothing pushed.
// 2. Single word: push 32'sd-5 at edge N (PERIOD=2).
//    -> m_out=-5, m_out_sync=1 after N+1 only; sync=0 after N+2; m_out stays -5.
// 3. Pacing and fill: push 1..6 back-to-back (DEPTH=4, PERIOD=2).
//    -> in_ready drops at full; strobes spaced exactly 2 cycles; values 1..6 in order, none lost.
// 4. PERIOD=1, continuous input.
//    -> m_out_sync high every cycle after the first; fifo_count stays <= 1; sent_count tracks pushes.
// 5. Wrap: preload sent_count to 16'hFFFE via 2 strobes past 65534.
//    -> reads 16'hFFFF then 16'h0000.
// 6. Mid-operation reset: reset with 3 words buffered and m_out_sync=1.
//    -> next cycle m_out_sync=0, fifo_count=0, m_out=0; post-reset push re-emits with 1-cycle latency.

Source files
------------

// File: rtl/ms_sync_producer_if.sv
// Producer-side channel bundle: the upstream valid/ready word stream plus the
// slave-facing data/sync pair.
interface ms_sync_producer_if #(
  parameter int DATA_W = 32
);
  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] m_out;
  logic                     m_out_sync;

  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output m_out,
    output m_out_sync
  );

  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  m_out,
    input  m_out_sync
  );
endinterface

// File: rtl/ms_sync_producer.sv
// Master-side producer for a shared-variable channel: buffers upstream words in
// a small FIFO and emits them to the slave with a paced one-cycle sync strobe.
module ms_sync_producer #(
  parameter int DEPTH  = 4,
  parameter int PERIOD = 2,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  ms_sync_producer_if.master         bus,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [15:0]                sent_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
  localparam logic [PW-1:0] PACE_INIT = PW'(PERIOD - 1);

  typedef enum logic {SEC_IDLE, SEC_PACE} sec_t;

  sec_t                     sec;
  sec_t                     sec_nxt;
  logic [PW-1:0]            pace;
  logic [PW-1:0]            pace_nxt;
  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic                     push;
  logic                     emit;

  // Section state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      sec  <= SEC_IDLE;
      pace <= '0;
    end else begin
      sec  <= sec_nxt;
      pace <= pace_nxt;
    end
  end

  // Next-section logic
  always_comb begin
    sec_nxt  = sec;
    pace_nxt = pace;
    case (sec)
      SEC_IDLE: begin
        if (emit) begin
          pace_nxt = PACE_INIT;
          sec_nxt  = (PERIOD > 1) ? SEC_PACE : SEC_IDLE;
        end
      end
      SEC_PACE: begin
        pace_nxt = pace - PW'(1);
        if (pace == PW'(1)) sec_nxt = SEC_IDLE;
      end
      default: begin
        sec_nxt  = SEC_IDLE;
        pace_nxt = '0;
      end
    endcase
  end

  // Section-derived controls; full refuses a push even when a pop coincides
  always_comb begin
    bus.in_ready = rst && (fifo_count != FULL);
    push         = bus.in_valid && bus.in_ready;
    emit         = (sec == SEC_IDLE) && (fifo_count != '0);
  end

  // FIFO storage carries data only, so it is left out of reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  // Occupancy, pointers and registered slave-facing outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      sent_count     <= '0;
      bus.m_out      <= '0;
      bus.m_out_sync <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      case ({push, emit})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      bus.m_out_sync <= emit;
      if (emit) begin
        bus.m_out  <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + AW'(1);
        sent_count <= sent_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ms_sync_producer.sv
// Directed bench: vector table on a PERIOD=2 instance, streaming and
// sent_count wrap sequence on a PERIOD=1 instance.
module tb_ms_sync_producer;

  logic       clk = 1'b0;
  logic       rst2;
  logic       rst1;
  logic [2:0] fc2;
  logic [2:0] fc1;
  logic [15:0] sc2;
  logic [15:0] sc1;

  int n_cmp = 0;
  int n_bad = 0;

  ms_sync_producer_if #(.DATA_W(32)) bus2 ();
  ms_sync_producer_if #(.DATA_W(32)) bus1 ();

  ms_sync_producer #(.DEPTH(4), .PERIOD(2), .DATA_W(32)) u_p2 (
    .clk(clk), .rst(rst2), .bus(bus2), .fifo_count(fc2), .sent_count(sc2)
  );

  ms_sync_producer #(.DEPTH(4), .PERIOD(1), .DATA_W(32)) u_p1 (
    .clk(clk), .rst(rst1), .bus(bus1), .fifo_count(fc1), .sent_count(sc1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic               rst;
    logic               vld;
    logic signed [31:0] d;
    logic               rdy;
    logic               sync;
    logic signed [31:0] out;
    int                 cnt;
    int                 sent;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic v, int d, logic rdy, logic s,
                              int o, int c, int sn);
    vec_t x;
    x.rst = r; x.vld = v; x.d = d; x.rdy = rdy; x.sync = s;
    x.out = o; x.cnt = c; x.sent = sn;
    return x;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %0d (0x%08h), expected %0d (0x%08h)",
               name, idx, $signed(act), act, $signed(exp), exp);
    end
  endtask

  initial begin
    rst2 = 1'b0; rst1 = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0;
    bus1.in_valid = 1'b0; bus1.in_data = '0;

    // reset held with in_valid high
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 99, 0, 0, 0, 0, 0));
    // single word, PERIOD=2
    tbl.push_back(mk(1, 1, -5, 1, 0,  0, 1, 0));
    tbl.push_back(mk(1, 0,  0, 1, 1, -5, 0, 1));
    tbl.push_back(mk(1, 0,  0, 1, 0, -5, 0, 1));
    // back-to-back fill, pacing, full refusal with a coincident pop
    tbl.push_back(mk(1, 1, 1, 1, 0, -5, 1, 1));
    tbl.push_back(mk(1, 1, 2, 1, 1,  1, 1, 2));
    tbl.push_back(mk(1, 1, 3, 1, 0,  1, 2, 2));
    tbl.push_back(mk(1, 1, 4, 1, 1,  2, 2, 3));
    tbl.push_back(mk(1, 1, 5, 1, 0,  2, 3, 3));
    tbl.push_back(mk(1, 1, 6, 1, 1,  3, 3, 4));
    tbl.push_back(mk(1, 1, 7, 0, 0,  3, 4, 4));
    tbl.push_back(mk(1, 1, 8, 1, 1,  4, 3, 5));
    tbl.push_back(mk(1, 1, 8, 0, 0,  4, 4, 5));
    tbl.push_back(mk(1, 0, 0, 1, 1,  5, 3, 6));
    tbl.push_back(mk(1, 0, 0, 1, 0,  5, 3, 6));
    tbl.push_back(mk(1, 0, 0, 1, 1,  6, 2, 7));
    tbl.push_back(mk(1, 0, 0, 1, 0,  6, 2, 7));
    tbl.push_back(mk(1, 0, 0, 1, 1,  7, 1, 8));
    tbl.push_back(mk(1, 0, 0, 1, 0,  7, 1, 8));
    tbl.push_back(mk(1, 0, 0, 1, 1,  8, 0, 9));
    tbl.push_back(mk(1, 0, 0, 1, 0,  8, 0, 9));
    tbl.push_back(mk(1, 0, 0, 1, 0,  8, 0, 9));
    // build up 3 buffered words with a strobe pending, then reset
    tbl.push_back(mk(1, 1, 10, 1, 0,  8, 1,  9));
    tbl.push_back(mk(1, 1, 11, 1, 1, 10, 1, 10));
    tbl.push_back(mk(1, 1, 12, 1, 0, 10, 2, 10));
    tbl.push_back(mk(1, 1, 13, 1, 1, 11, 2, 11));
    tbl.push_back(mk(1, 1, 14, 1, 0, 11, 3, 11));
    tbl.push_back(mk(1, 1, 15, 1, 1, 12, 3, 12));
    tbl.push_back(mk(0, 1, 16, 0, 0,  0, 0,  0));
    tbl.push_back(mk(1, 1, -7, 1, 0,  0, 1,  0));
    tbl.push_back(mk(1, 0,  0, 1, 1, -7, 0,  1));
    tbl.push_back(mk(1, 0,  0, 1, 0, -7, 0,  1));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst2 = tbl[i].rst; bus2.in_valid = tbl[i].vld; bus2.in_data = tbl[i].d;
      @(posedge clk); #1;
      check("p2_in_ready",   i, 32'(bus2.in_ready),   32'(tbl[i].rdy));
      check("p2_m_out_sync", i, 32'(bus2.m_out_sync), 32'(tbl[i].sync));
      check("p2_m_out",      i, bus2.m_out,           tbl[i].out);
      check("p2_fifo_count", i, 32'(fc2),             tbl[i].cnt);
      check("p2_sent_count", i, 32'(sc2),             tbl[i].sent);
    end
    @(negedge clk);
    bus2.in_valid = 1'b0;

    // PERIOD=1 continuous stream: edge k pushes k and emits k-1
    @(negedge clk); rst1 = 1'b0;
    @(posedge clk); #1;
    check("p1_reset_sync",  0, 32'(bus1.m_out_sync), 32'd0);
    check("p1_reset_ready", 0, 32'(bus1.in_ready),   32'd0);
    for (int k = 1; k <= 65538; k++) begin
      @(negedge clk);
      rst1 = 1'b1; bus1.in_valid = 1'b1; bus1.in_data = k;
      @(posedge clk); #1;
      if (k <= 20 || k >= 65535) begin
        if (k == 1) begin
          check("p1_first_sync", k, 32'(bus1.m_out_sync), 32'd0);
          check("p1_first_cnt",  k, 32'(fc1),             32'd1);
          check("p1_first_sent", k, 32'(sc1),             32'd0);
        end else begin
          check("p1_sync",  k, 32'(bus1.m_out_sync), 32'd1);
          check("p1_out",   k, bus1.m_out,           k - 1);
          check("p1_cnt",   k, 32'(fc1),             32'd1);
          check("p1_sent",  k, 32'(sc1),             (k - 1) & 32'hFFFF);
          check("p1_ready", k, 32'(bus1.in_ready),   32'd1);
        end
      end
    end
    @(negedge clk);
    bus1.in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
